muldiv_sequencer: RTL and testbench

- Multi-cycle controller for the MULT/MULTU/DIV/DIVU group of the ALU; owns the architectural HI/LO registers.
- The single-cycle ALU decodes funct and raises `start` with the operand pair (gr1 = rs, gr2 = rt).
- The sequencer runs a 32-step iterative shift-add multiply or restoring divide and holds `busy` for the whole operation.
- The pipeline stalls MFHI/MFLO on `busy`.

---
 rtl/muldiv_pkg.sv | 6 +
 rtl/muldiv_step.sv | 21 ++
 rtl/muldiv_sequencer.sv | 177 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and iteration count for the HI/LO multiply-divide unit.
package muldiv_pkg;
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_e;
  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_e;
  localparam int MULDIV_STEPS = 32;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one iteration of shift-add multiply (right shift) or restoring divide (left shift).
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] qr_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] qr_o
);
  logic [WIDTH:0] sum, rsh, diff;
  // The remainder stays below the divisor, so rsh fits in WIDTH+1 bits and diff's MSB is the borrow.
  always_comb begin
    sum  = {1'b0, acc_i} + (qr_i[0] ? {1'b0, m_i} : '0);
    rsh  = {acc_i, qr_i[WIDTH-1]};
    diff = rsh - {1'b0, m_i};
    acc_o = is_div_i ? (diff[WIDTH] ? rsh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    qr_o  = is_div_i ? {qr_i[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], qr_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU controller owning HI/LO.
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single combinational step during PREP.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_STEPS,
  parameter int STEPS = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(STEPS);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, qr_q, qr_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, ovf_q, ovf_d;
  logic done_q, done_d, dzo_q, dzo_d, ovo_q, ovo_d;
  logic is_div, is_signed;
  logic [WIDTH-1:0] abs_a, abs_b, step_acc, step_qr, quo, rem, min_neg;
  logic [2*WIDTH-1:0] prod, prod_n;

  assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign min_neg   = {1'b1, {(WIDTH-1){1'b0}}};
  assign abs_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign abs_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
  assign prod      = {acc_q, qr_q};
  assign prod_n    = neg_q ? -prod : prod;
  assign quo       = neg_q ? -qr_q : qr_q;
  assign rem       = rneg_q ? -acc_q : acc_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i(is_div),
    .acc_i   (acc_q),
    .qr_i    (qr_q),
    .m_i     (m_q),
    .acc_o   (step_acc),
    .qr_o    (step_qr)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    qr_d    = qr_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    dzo_d   = 1'b0;
    ovo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        hi_d = hi_we ? wdata : hi_q;
        lo_d = lo_we ? wdata : lo_q;
        if (start && !flush) begin
          state_d = S_PREP;
          op_d    = op_e'(op);
          a_d     = rs_val;
          b_d     = rt_val;
        end
      end
      S_PREP: begin
        neg_d   = is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rneg_d  = is_signed && a_q[WIDTH-1];
        dz_d    = is_div && (b_q == '0);
        ovf_d   = (op_q == OP_DIV) && (a_q == min_neg) && (b_q == '1);
        acc_d   = '0;
        qr_d    = is_div ? abs_a : abs_b;
        m_d     = is_div ? abs_b : abs_a;
        cnt_d   = CW'(STEPS - 1);
        state_d = (dz_d || ovf_d) ? S_FIX : S_RUN;
`ifdef MULDIV_FAST_MUL_EN
        if (!is_div) begin
          {acc_d, qr_d} = (2*WIDTH)'(abs_a) * (2*WIDTH)'(abs_b);
          state_d = S_FIX;
        end
`endif
      end
      S_RUN: begin
        acc_d   = step_acc;
        qr_d    = step_qr;
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == '0) ? S_FIX : S_RUN;
      end
      S_FIX: begin
        hi_d    = dz_q ? a_q : ovf_q ? '0 : is_div ? rem : prod_n[2*WIDTH-1:WIDTH];
        lo_d    = dz_q ? '1 : ovf_q ? min_neg : is_div ? quo : prod_n[WIDTH-1:0];
        done_d  = 1'b1;
        dzo_d   = dz_q;
        ovo_d   = ovf_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A squash abandons the operation without touching HI/LO or signalling completion.
    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dzo_d   = 1'b0;
      ovo_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      qr_q    <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      dzo_q   <= 1'b0;
      ovo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      qr_q    <= qr_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      dzo_q   <= dzo_d;
      ovo_q   <= ovo_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = ~ready;
  assign done     = done_q;
  assign div_zero = dzo_q;
  assign overflow = ovo_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
  localparam logic [1:0] FLUSH_OP = 2'b11;
`else
  localparam int MUL_LAT = 34;
  localparam logic [1:0] FLUSH_OP = 2'b00;
`endif
  localparam int DIV_LAT = 34;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0] op = 2'b00;
  logic [W-1:0] rs_val = '0, rt_val = '0, wdata = '0;
  logic ready, busy, done, div_zero, overflow;
  logic [W-1:0] hi, lo;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .div_zero(div_zero), .overflow(overflow),
    .hi(hi), .lo(lo)
  );

  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk); op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int lat, output int bcnt, output logic dz, output logic ov);
    lat = -1; bcnt = busy; dz = 1'b0; ov = 1'b0;
    for (int n = n0 + 1; n <= n0 + 200; n++) begin
      @(posedge clk); #1;
      bcnt += int'(busy);
      if (done) begin lat = n; dz = div_zero; ov = overflow; break; end
    end
    if (lat < 0) begin checks++; failures++; $display("FAIL wait_done timeout: no done within 200 cycles"); end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (hi !== '0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== '0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if ({ready, busy, done, div_zero, overflow} !== 5'b10000) begin failures++; $display("FAIL reset_flags got=%b exp=10000", {ready, busy, done, div_zero, overflow}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult_timing();
    int lat, bcnt; logic dz, ov;
    launch(2'b00, 32'h00FFFFFF, 32'h00FFFFFF);
    wait_done(0, lat, bcnt, dz, ov);
    checks++; if (hi !== 32'h0000FFFF) begin failures++; $display("FAIL mult_ff_hi got=%h exp=0000ffff", hi); end
    checks++; if (lo !== 32'hFE000001) begin failures++; $display("FAIL mult_ff_lo got=%h exp=fe000001", lo); end
    checks++; if (lat != MUL_LAT) begin failures++; $display("FAIL mult_latency got=%0d exp=%0d", lat, MUL_LAT); end
    checks++; if (bcnt != MUL_LAT) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=%0d", bcnt, MUL_LAT); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL mult_ready_at_done got=%b exp=1", ready); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", done); end
  endtask

  task automatic test_mult_signs();
    int lat, bcnt; logic dz, ov;
    launch(2'b00, 32'hFFFFFFFE, 32'h4);
    wait_done(0, lat, bcnt, dz, ov);
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF8) begin failures++; $display("FAIL mult_neg got=%h_%h exp=ffffffff_fffffff8", hi, lo); end
    launch(2'b01, 32'h80000001, 32'h1);
    wait_done(0, lat, bcnt, dz, ov);
    checks++; if ({hi, lo} !== 64'h00000000_80000001) begin failures++; $display("FAIL multu_one got=%h_%h exp=00000000_80000001", hi, lo); end
    launch(2'b00, 32'h80000000, 32'h80000000);
    wait_done(0, lat, bcnt, dz, ov);
    checks++; if ({hi, lo} !== 64'h40000000_00000000) begin failures++; $display("FAIL mult_minneg_sq got=%h_%h exp=40000000_00000000", hi, lo); end
    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, lat, bcnt, dz, ov);
    checks++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin failures++; $display("FAIL multu_max got=%h_%h exp=fffffffe_00000001", hi, lo); end
  endtask

  task automatic test_div();
    int lat, bcnt; logic dz, ov;
    launch(2'b10, 32'd8, 32'hFFFFFFFD);
    wait_done(0, lat, bcnt, dz, ov);
    checks++; if ({hi, lo} !== 64'h00000002_FFFFFFFE) begin failures++; $display("FAIL div_8_m3 got=%h_%h exp=00000002_fffffffe", hi, lo); end
    checks++; if (lat != DIV_LAT) begin failures++; $display("FAIL div_latency got=%0d exp=%0d", lat, DIV_LAT); end
    checks++; if ({dz, ov} !== 2'b00) begin failures++; $display("FAIL div_flags got=%b exp=00", {dz, ov}); end
    launch(2'b10, 32'd2, 32'hFFFFFFFD);
    wait_done(0, lat, bcnt, dz, ov);
    checks++; if ({hi, lo} !== 64'h00000002_00000000) begin failures++; $display("FAIL div_2_m3 got=%h_%h exp=00000002_00000000", hi, lo); end
    launch(2'b11, 32'h80000000, 32'h1);
    wait_done(0, lat, bcnt, dz, ov);
    checks++; if ({hi, lo} !== 64'h00000000_80000000) begin failures++; $display("FAIL divu_minneg got=%h_%h exp=00000000_80000000", hi, lo); end
    launch(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(0, lat, bcnt, dz, ov);
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin failures++; $display("FAIL div_m7_2 got=%h_%h exp=ffffffff_fffffffd", hi, lo); end
  endtask

  task automatic test_special();
    int lat, bcnt; logic dz, ov;
    launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(0, lat, bcnt, dz, ov);
    checks++; if ({hi, lo} !== 64'h00000000_80000000) begin failures++; $display("FAIL ovf_result got=%h_%h exp=00000000_80000000", hi, lo); end
    checks++; if ({dz, ov} !== 2'b01) begin failures++; $display("FAIL ovf_flags got=%b exp=01", {dz, ov}); end
    checks++; if (lat != 2) begin failures++; $display("FAIL ovf_latency got=%0d exp=2", lat); end
    @(posedge clk); #1;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_pulse got=%b exp=0", overflow); end
    launch(2'b11, 32'd5, 32'd0);
    wait_done(0, lat, bcnt, dz, ov);
    checks++; if ({hi, lo} !== 64'h00000005_FFFFFFFF) begin failures++; $display("FAIL dz_result got=%h_%h exp=00000005_ffffffff", hi, lo); end
    checks++; if ({dz, ov} !== 2'b10) begin failures++; $display("FAIL dz_flags got=%b exp=10", {dz, ov}); end
    checks++; if (lat != 2) begin failures++; $display("FAIL dz_latency got=%0d exp=2", lat); end
    @(posedge clk); #1;
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL dz_pulse got=%b exp=0", div_zero); end
  endtask

  task automatic test_flush();
    int lat, bcnt; logic dz, ov, seen;
    hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
    @(posedge clk); #1; lo_we = 1'b0;
    checks++; if ({hi, lo} !== 64'h00001234_00005678) begin failures++; $display("FAIL mthi_mtlo got=%h_%h exp=00001234_00005678", hi, lo); end
    launch(FLUSH_OP, 32'd3, 32'd3);
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; seen |= done; end
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    seen |= done;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", ready); end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_done got=%b exp=0", seen); end
    checks++; if ({hi, lo} !== 64'h00001234_00005678) begin failures++; $display("FAIL flush_hilo got=%h_%h exp=00001234_00005678", hi, lo); end
    launch(2'b00, 32'd3, 32'd3);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL restart_accept got=%b exp=1", busy); end
    wait_done(0, lat, bcnt, dz, ov);
    checks++; if ({hi, lo} !== 64'h00000000_00000009) begin failures++; $display("FAIL restart_result got=%h_%h exp=00000000_00000009", hi, lo); end
    checks++; if (lat != MUL_LAT) begin failures++; $display("FAIL restart_latency got=%0d exp=%0d", lat, MUL_LAT); end
    @(negedge clk); flush = 1'b1; start = 1'b1; op = 2'b01; rs_val = 32'd2; rt_val = 32'd2;
    @(posedge clk); #1; flush = 1'b0; start = 1'b0;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL idle_flush_start got=%b exp=1", ready); end
  endtask

  task automatic test_busy_ignore();
    int lat, bcnt; logic dz, ov;
    logic [W-1:0] lo_prev;
    lo_prev = lo;
    hi_we = 1'b1; wdata = 32'hABCD;
    launch(2'b11, 32'd44, 32'd6);
    hi_we = 1'b0;
    checks++; if (hi !== 32'hABCD) begin failures++; $display("FAIL start_mthi got=%h exp=0000abcd", hi); end
    repeat (3) begin @(posedge clk); #1; end
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD; start = 1'b1; op = 2'b00; rs_val = 32'd3; rt_val = 32'd3;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
    checks++; if ({hi, lo} !== {32'hABCD, lo_prev}) begin failures++; $display("FAIL busy_write_drop got=%h_%h exp=%h_%h", hi, lo, 32'hABCD, lo_prev); end
    wait_done(4, lat, bcnt, dz, ov);
    checks++; if ({hi, lo} !== 64'h00000002_00000007) begin failures++; $display("FAIL divu_44_6 got=%h_%h exp=00000002_00000007", hi, lo); end
    checks++; if (lat != DIV_LAT) begin failures++; $display("FAIL busy_ignore_latency got=%0d exp=%0d", lat, DIV_LAT); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL no_queue got=%b exp=0", busy); end
  endtask

  task automatic test_async_reset();
    int lat, bcnt; logic dz, ov;
    launch(2'b10, 32'd100, 32'd7);
    repeat (15) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL areset_hilo got=%h_%h exp=0", hi, lo); end
    checks++; if ({ready, busy, done, div_zero, overflow} !== 5'b10000) begin failures++; $display("FAIL areset_flags got=%b exp=10000", {ready, busy, done, div_zero, overflow}); end
    @(negedge clk); rst_n = 1'b1;
    launch(2'b11, 32'd100, 32'd7);
    wait_done(0, lat, bcnt, dz, ov);
    checks++; if ({hi, lo} !== 64'h00000002_0000000E) begin failures++; $display("FAIL post_reset_divu got=%h_%h exp=00000002_0000000e", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult_timing();
    test_mult_signs();
    test_div();
    test_special();
    test_flush();
    test_busy_ignore();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
